mt9v032_px_stream: RTL

// - Downstream of mt9v032_top: takes one channel's px/line_valid/frame_valid in the clk_px domain.
// - Produces a valid/ready pixel stream with sof/eol/eof markers, buffered in a small FIFO.
// - Measures line width and frame height, and flags overflow and inconsistent lines for debug.

---
 rtl/mt9v032_pkg.sv | 26 ++
 rtl/mt9v032_px_fifo.sv | 53 +++++
 rtl/mt9v032_px_stream.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/mt9v032_pkg.sv
// rtl/mt9v032_pkg.sv - shared state encoding and FIFO entry layout for the mt9v032 pixel stream
package mt9v032_pkg;

  typedef enum logic [1:0] {
    ST_SYNC   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_DROP   = 2'd3
  } px_state_t;

  // Marker bits sit directly above the pixel data in each FIFO entry.
  localparam int MK_SOF = 0;
  localparam int MK_EOL = 1;
  localparam int MK_EOF = 2;
  localparam int MK_W   = 3;

  function automatic logic [MK_W-1:0] pack_marks(input logic sof, input logic eol, input logic eof);
    logic [MK_W-1:0] mk;
    mk         = '0;
    mk[MK_SOF] = sof;
    mk[MK_EOL] = eol;
    mk[MK_EOF] = eof;
    return mk;
  endfunction

endpackage

// File: rtl/mt9v032_px_fifo.sv
// rtl/mt9v032_px_fifo.sv - synchronous show-ahead FIFO; a full FIFO still accepts a push when popped
module mt9v032_px_fifo
#(
  parameter int W    = 13,
  parameter int ADDR = 4
)
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);

  localparam int DEPTH = 1 << ADDR;

  logic [W-1:0]    mem [DEPTH];
  logic [ADDR-1:0] wr_ptr;
  logic [ADDR-1:0] rd_ptr;
  logic [ADDR:0]   count;
  logic            do_push;
  logic            do_pop;

  assign full     = (count == (ADDR+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + ADDR'(1);
      if (do_pop)  rd_ptr <= rd_ptr + ADDR'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (ADDR+1)'(1);
        2'b01:   count <= count - (ADDR+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mt9v032_px_stream.sv
// rtl/mt9v032_px_stream.sv - turns sensor px/line_valid/frame_valid into a marked valid/ready stream
// with line/frame statistics and sticky overflow/line-width error flags.
module mt9v032_px_stream
  import mt9v032_pkg::*;
#(
  parameter int DATA = 10,
  parameter int ADDR = 4,
  parameter int XB   = 10,
  parameter int YB   = 10
)
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [DATA-1:0] px,
  input  logic            line_valid,
  input  logic            frame_valid,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [DATA-1:0] out_data,
  output logic            out_sof,
  output logic            out_eol,
  output logic            out_eof,
  input  logic            clear_err,
  output logic            overflow,
  output logic            line_err,
  output logic            stats_valid,
  output logic [XB-1:0]   line_width,
  output logic [YB-1:0]   frame_height
);

  localparam int EW = DATA + MK_W;

  logic [DATA-1:0] px_q;
  logic            lv_q, lv_d, fv_q, fv_d;
  logic            fv_rise, fv_fall, lv_fall, strobe;

  px_state_t       state, state_nx;
  logic            refused, in_frame, take, frame_start, frame_end, line_end;

  logic            hold_valid, hold_valid_nx;
  logic            hold_sof, hold_sof_nx;
  logic            hold_eol, hold_eol_nx;
  logic            sof_pend, sof_pend_nx;
  logic [DATA-1:0] hold_data, hold_data_nx;

  logic            push_valid, push_nx;
  logic [EW-1:0]   push_entry, entry_nx;

  logic            fifo_full, fifo_empty, pop;
  logic [EW-1:0]   fifo_data;

  logic [XB-1:0]   x, ref_w, x_inc, ref_after;
  logic [YB-1:0]   y, y_inc, y_after;
  logic            err_evt;

  // frame_valid samples reset to 1 so a reset released mid-frame is seen as "frame in progress".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      px_q <= '0;
      lv_q <= 1'b0;
      lv_d <= 1'b0;
      fv_q <= 1'b1;
      fv_d <= 1'b1;
    end else begin
      px_q <= px;
      lv_q <= line_valid;
      lv_d <= lv_q;
      fv_q <= frame_valid;
      fv_d <= fv_q;
    end
  end

  assign fv_rise = fv_q & ~fv_d;
  assign fv_fall = ~fv_q & fv_d;
  assign lv_fall = ~lv_q & lv_d;
  assign strobe  = fv_q & lv_q;

  assign out_valid = ~fifo_empty;
  assign pop       = out_valid & out_ready;
  assign refused   = push_valid & fifo_full & ~pop;

  assign in_frame    = (state == ST_ACTIVE) | ((state == ST_ARMED) & fv_rise);
  assign take        = in_frame & ~refused;
  assign frame_start = take & (state == ST_ARMED);
  assign frame_end   = take & (state == ST_ACTIVE) & fv_fall;
  assign line_end    = take & (state == ST_ACTIVE) & lv_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_SYNC;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_SYNC:   if (!fv_q)   state_nx = ST_ARMED;
      ST_ARMED:  if (fv_rise) state_nx = ST_ACTIVE;
      ST_ACTIVE: if (fv_fall) state_nx = ST_ARMED;
      ST_DROP:   if (!fv_q)   state_nx = ST_ARMED;
      default:                state_nx = ST_SYNC;
    endcase
    if (refused) state_nx = ST_DROP;
  end

  // One-entry hold stage: a pixel's eol/eof is only known once the next event arrives.
  always_comb begin
    hold_valid_nx = hold_valid;
    hold_sof_nx   = hold_sof;
    hold_eol_nx   = hold_eol;
    hold_data_nx  = hold_data;
    sof_pend_nx   = sof_pend;
    push_nx       = 1'b0;
    entry_nx      = {pack_marks(hold_sof, hold_eol, 1'b0), hold_data};
    if (take) begin
      if (strobe) begin
        push_nx       = hold_valid;
        hold_valid_nx = 1'b1;
        hold_data_nx  = px_q;
        hold_sof_nx   = sof_pend | (state == ST_ARMED);
        hold_eol_nx   = 1'b0;
        sof_pend_nx   = 1'b0;
      end else if (fv_fall) begin
        push_nx       = hold_valid;
        entry_nx      = {pack_marks(hold_sof, 1'b1, 1'b1), hold_data};
        hold_valid_nx = 1'b0;
        sof_pend_nx   = 1'b0;
      end else begin
        if (lv_fall && hold_valid) hold_eol_nx = 1'b1;
        if (state == ST_ARMED)     sof_pend_nx = 1'b1;
      end
    end
    if (refused) begin
      hold_valid_nx = 1'b0;
      sof_pend_nx   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid <= 1'b0;
      hold_sof   <= 1'b0;
      hold_eol   <= 1'b0;
      hold_data  <= '0;
      sof_pend   <= 1'b0;
      push_valid <= 1'b0;
      push_entry <= '0;
    end else begin
      hold_valid <= hold_valid_nx;
      hold_sof   <= hold_sof_nx;
      hold_eol   <= hold_eol_nx;
      hold_data  <= hold_data_nx;
      sof_pend   <= sof_pend_nx;
      push_valid <= push_nx;
      push_entry <= entry_nx;
    end
  end

  mt9v032_px_fifo #(.W(EW), .ADDR(ADDR)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_valid),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Stale memory contents never reach the outputs while the FIFO is empty.
  assign out_data = out_valid ? fifo_data[DATA-1:0] : '0;
  assign out_sof  = out_valid & fifo_data[DATA+MK_SOF];
  assign out_eol  = out_valid & fifo_data[DATA+MK_EOL];
  assign out_eof  = out_valid & fifo_data[DATA+MK_EOF];

  assign x_inc     = (&x) ? x : x + XB'(1);
  assign y_inc     = (&y) ? y : y + YB'(1);
  assign ref_after = (line_end && (y == '0)) ? x : ref_w;
  assign y_after   = line_end ? y_inc : y;
  assign err_evt   = line_end & (y != '0) & (x != ref_w);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x            <= '0;
      y            <= '0;
      ref_w        <= '0;
      stats_valid  <= 1'b0;
      line_width   <= '0;
      frame_height <= '0;
      line_err     <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      stats_valid <= frame_end;
      if (frame_start) begin
        x     <= XB'(strobe);
        y     <= '0;
        ref_w <= '0;
      end else if (take) begin
        if (strobe) x <= x_inc;
        if (line_end) begin
          x     <= '0;
          y     <= y_inc;
          ref_w <= ref_after;
        end
      end
      if (frame_end) begin
        line_width   <= ref_after;
        frame_height <= y_after;
      end
      if (err_evt)        line_err <= 1'b1;
      else if (clear_err) line_err <= 1'b0;
      if (refused)        overflow <= 1'b1;
      else if (clear_err) overflow <= 1'b0;
    end
  end

endmodule
